// File: rtl/button_event_gen.sv
// Turns the debounced button level into press, release, short, long and
// auto-repeat pulses, and keeps a wrapping press counter.
module button_event_gen #(
    parameter int LONG_CNT   = 1000,
    parameter int REPEAT_CNT = 250,
    parameter int CNT_W      = 16
) (
    input  logic       msclk,
    input  logic       rst_n,
    input  logic       cleanbtn,
    output logic       press_p,
    output logic       release_p,
    output logic       short_p,
    output logic       long_p,
    output logic       rep_p,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HELD
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             btn_q;
    logic             rise;
    logic             press_d;
    logic             release_d;
    logic             short_d;
    logic             long_d;
    logic             rep_d;
    logic             held_d;
    logic [7:0]       count_d;

    assign rise = cleanbtn & ~btn_q;

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        rep_d     = 1'b0;
        held_d    = held;
        count_d   = press_count;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    count_d = press_count + 8'd1;
                    cnt_d   = '0;
                    state_d = PRESS;
                end
            end
            PRESS: begin
                if (!cleanbtn) begin
                    release_d = 1'b1;
                    short_d   = 1'b1;
                    state_d   = IDLE;
                end else if (cnt == LONG_LAST) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    held_d  = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            HELD: begin
                // Release from HELD is never a short press.
                if (!cleanbtn) begin
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (cnt == REP_LAST) begin
                    rep_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                held_d  = 1'b0;
            end
        endcase
    end

    // btn_q resets high so a button held through reset needs a fresh press.
    always_ff @(posedge msclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_q       <= 1'b1;
            press_p     <= 1'b0;
            release_p   <= 1'b0;
            short_p     <= 1'b0;
            long_p      <= 1'b0;
            rep_p       <= 1'b0;
            held        <= 1'b0;
            press_count <= 8'd0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            btn_q       <= cleanbtn;
            press_p     <= press_d;
            release_p   <= release_d;
            short_p     <= short_d;
            long_p      <= long_d;
            rep_p       <= rep_d;
            held        <= held_d;
            press_count <= count_d;
        end
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Self-checking bench for button_event_gen against a press-age model
// with LONG_CNT=4, REPEAT_CNT=3.
module tb_button_event_gen;

    localparam int L = 4;
    localparam int R = 3;

    logic       msclk = 1'b0;
    logic       rst_n;
    logic       cleanbtn;
    logic       press_p;
    logic       release_p;
    logic       short_p;
    logic       long_p;
    logic       rep_p;
    logic       held;
    logic [7:0] press_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: age of the current press in cycles since press_p.
    bit       m_prev;
    bit       m_act;
    int       m_age;
    logic [7:0] m_cnt;

    button_event_gen #(
        .LONG_CNT  (L),
        .REPEAT_CNT(R),
        .CNT_W     (16)
    ) dut (
        .msclk      (msclk),
        .rst_n      (rst_n),
        .cleanbtn   (cleanbtn),
        .press_p    (press_p),
        .release_p  (release_p),
        .short_p    (short_p),
        .long_p     (long_p),
        .rep_p      (rep_p),
        .held       (held),
        .press_count(press_count)
    );

    always #5 msclk = ~msclk;

    function automatic logic [13:0] obs();
        return {press_p, release_p, short_p, long_p, rep_p, held, press_count};
    endfunction

    task automatic model_reset();
        m_prev = 1'b1;
        m_act  = 1'b0;
        m_age  = 0;
        m_cnt  = 8'd0;
    endtask

    task automatic model_step(input logic c, output logic [13:0] e);
        logic p, r, s, lg, rp, h;
        p = 0; r = 0; s = 0; lg = 0; rp = 0;
        if (!m_act) begin
            if (c && !m_prev) begin
                p     = 1;
                m_act = 1;
                m_age = 0;
                m_cnt = m_cnt + 8'd1;
            end
        end else begin
            m_age++;
            if (!c) begin
                r     = 1;
                s     = (m_age <= L);
                m_act = 0;
            end else if (m_age == L) begin
                lg = 1;
            end else if (m_age > L && (m_age - L) % R == 0) begin
                rp = 1;
            end
        end
        m_prev = c;
        h = m_act && (m_age >= L);
        e = {p, r, s, lg, rp, h, m_cnt};
    endtask

    // Drive one sample, let the edge pass, advance the model.
    task automatic cyc(input logic c, output logic [13:0] e);
        cleanbtn = c;
        @(posedge msclk);
        #1;
        model_step(c, e);
    endtask

    task automatic test_reset();
        logic [13:0] e;
        rst_n    = 1'b1;
        cleanbtn = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge msclk);
        #1;
        n_cmp++;
        if (obs() !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %b want %b", obs(), 14'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc((i < 10) || (i >= 13), e);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL reset_held i=%0d: got %b want %b", i, obs(), e);
            end
        end
        n_cmp++;
        if (press_count !== 8'd1) begin
            n_bad++;
            $display("FAIL reset_first_count: got %0d want 1", press_count);
        end
    endtask

    task automatic run_pattern(input string name, input int lo, input int hi,
                               input int tail);
        logic [13:0] e;
        for (int i = 0; i < lo + hi + tail; i++) begin
            cyc((i >= lo) && (i < lo + hi), e);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL %s i=%0d: got %b want %b", name, i, obs(), e);
            end
        end
    endtask

    task automatic test_short();
        run_pattern("short", 2, 4, 3);
    endtask

    task automatic test_long();
        run_pattern("long", 2, 5, 3);
    endtask

    task automatic test_repeat();
        run_pattern("repeat", 2, 12, 3);
    endtask

    task automatic test_wrap();
        logic [13:0] e;
        logic [7:0]  start;
        start = m_cnt;
        for (int i = 0; i < 512; i++) begin
            cyc(i % 2 == 0, e);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL wrap i=%0d: got %b want %b", i, obs(), e);
            end
        end
        n_cmp++;
        if (press_count !== start) begin
            n_bad++;
            $display("FAIL wrap_count: got %0d want %0d", press_count, start);
        end
    endtask

    task automatic test_random();
        logic [13:0] e;
        logic        lvl;
        int          len;
        lvl = 1'b0;
        for (int run = 0; run < 80; run++) begin
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) begin
                cyc(lvl, e);
                n_cmp++;
                if (obs() !== e) begin
                    n_bad++;
                    $display("FAIL random r=%0d i=%0d: got %b want %b",
                             run, i, obs(), e);
                end
                n_cmp++;
                if ((short_p && !release_p) || (long_p && rep_p) ||
                    (press_p && release_p)) begin
                    n_bad++;
                    $display("FAIL random_excl r=%0d: got %b want none",
                             run, obs());
                end
            end
            lvl = ~lvl;
        end
    endtask

    task automatic test_async_reset();
        logic [13:0] e;
        run_pattern("pre_arst", 1, 7, 0);
        n_cmp++;
        if (held !== 1'b1) begin
            n_bad++;
            $display("FAIL arst_pre_held: got %b want 1", held);
        end
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (obs() !== 14'd0) begin
            n_bad++;
            $display("FAIL arst_immediate: got %b want %b", obs(), 14'd0);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(i < 6, e);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL arst_after i=%0d: got %b want %b", i, obs(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_repeat();
        test_wrap();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
Sits directly downstream of the push-button debouncer. Consumes its debounced level (cleanbtn) and converts it into single-cycle event pulses for the Enigma control logic:
- press
- release
- short press
- long press
- auto-repeat while held

Also keeps a wrapping press counter. The Enigma control logic uses these pulses to step rotor and letter selections.

Parameters:
LONG_CNT, 1000, cycles of continued high (after the press cycle) needed to classify a long press; legal range 2..2^CNT_W-1
REPEAT_CNT, 250, period in cycles of rep_p pulses once in HELD; legal range 1..2^CNT_W-1
CNT_W, 16, width of the internal cycle counter

Ports:
msclk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
cleanbtn  input  1  debounced button level, synchronous to msclk
press_p  output  1  one-cycle pulse on button press (rising edge of cleanbtn)
release_p  output  1  one-cycle pulse on button release (falling edge of cleanbtn)
short_p  output  1  one-cycle pulse, coincident with release_p, when released before long classification
long_p  output  1  one-cycle pulse when the press is classified long
rep_p  output  1  one-cycle auto-repeat pulse while held in HELD
held  output  1  level, high while in HELD
press_count  output  8  number of press_p pulses since reset, wraps 255->0

Behaviour:
- All outputs are registered. No combinational path from cleanbtn to any output.
- Reset (rst_n=0, asynchronous, any time including mid-press):
  - all pulse outputs, held and press_count = 0
  - FSM = IDLE, cnt = 0
  - btn_q (previous-sample register) = 1, so a button already held at reset release is ignored until it is released and pressed again.
- Rise = cleanbtn==1 && btn_q==0. Fall = cleanbtn==0 && btn_q==1. btn_q <= cleanbtn every cycle.
- Pulse outputs default to 0 each cycle. Each is high for exactly one cycle when asserted.
- FSM states: IDLE, PRESS, HELD.
- IDLE:
  - on rise: press_p<=1, press_count<=press_count+1, cnt<=0, go to PRESS
  - otherwise stay in IDLE
- PRESS:
  - on cleanbtn==0: release_p<=1, short_p<=1, go to IDLE
  - else if cnt==LONG_CNT-1: long_p<=1, cnt<=0, held<=1, go to HELD
  - else cnt<=cnt+1
- HELD:
  - on cleanbtn==0: release_p<=1, held<=0, cnt<=0, go to IDLE (no short_p)
  - else if cnt==REPEAT_CNT-1: rep_p<=1, cnt<=0
  - else cnt<=cnt+1
- Latency, with the rising edge first sampled at posedge k:
  - press_p registered at posedge k
  - long_p at posedge k+LONG_CNT, only if cleanbtn is high at samples k..k+LONG_CNT
  - rep_p at posedges k+LONG_CNT+n*REPEAT_CNT, n>=1
- Release in PRESS at the sample where cleanbtn is first 0 gives release_p and short_p at that posedge.
- Boundaries:
  - 1-cycle-wide cleanbtn high: press_p, then release_p+short_p on the next cycle.
  - long_p and rep_p never coincide.
  - short_p never appears without release_p.
  - press_p and release_p never coincide.
  - The counter never exceeds max(LONG_CNT, REPEAT_CNT)-1.
  - press_count wraps silently.

Test Plan (LONG_CNT=4, REPEAT_CNT=3 overrides):
1. Reset while cleanbtn=1 and held for 10 cycles, then cleanbtn=0 -> no pulses at all, press_count=0; next rise -> press_p, press_count=1.
2. cleanbtn high for samples k..k+3, low at k+4 -> press_p@k, release_p+short_p@k+4, no long_p.
3. cleanbtn high for samples k..k+4, low at k+5 -> press_p@k, long_p@k+4, held=1, release_p@k+5 without short_p, held=0.
4. cleanbtn held high k..k+11 -> long_p@k+4, rep_p@k+7 and @k+10, no other pulses; release@k+12 -> release_p@k+12.
5. 1-cycle high pulse on cleanbtn -> press_p then release_p+short_p on consecutive cycles; repeat 256 presses -> press_count returns to 0.
6. Assert rst_n=0 asynchronously mid-HELD (between clock edges) -> all outputs 0 immediately, before the next msclk edge; no release_p after reset deasserts while button still held.
